// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter sharing one bank of SR flag bits between N_REQ requesters.
// Optional handshake counter output cmd_cnt when SR_ARB_STATS_EN is defined.
module sr_cmd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_FLAGS = 8,
    parameter int IDX_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_s,
    input  logic [N_REQ-1:0]       req_r,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_FLAGS-1:0]     flags,
    output logic                   err,
    output logic [2:0]             err_req,
    output logic [IDX_W-1:0]       err_idx
`ifdef SR_ARB_STATS_EN
    ,
    output logic [15:0]            cmd_cnt
`endif
);

    logic [2:0]         rr_ptr;
    logic [2:0]         gnt_id;
    logic               gnt_any;
    logic               cmd_s;
    logic               cmd_r;
    logic [IDX_W-1:0]   cmd_idx;
    logic               oob;
    logic               bad;
    logic [N_FLAGS-1:0] flags_nxt;

    // Rotating priority search starting at rr_ptr; nothing is granted during reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_any && req_valid[k] && (k == (int'(rr_ptr) + i) % N_REQ)) begin
                    gnt_any = 1'b1;
                    gnt_id  = 3'(k);
                end
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = gnt_any && (gnt_id == 3'(k));
        end
    end

    always_comb begin
        cmd_s   = 1'b0;
        cmd_r   = 1'b0;
        cmd_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_id == 3'(k)) begin
                cmd_s   = req_s[k];
                cmd_r   = req_r[k];
                cmd_idx = req_idx[k*IDX_W +: IDX_W];
            end
        end
    end

    // Out-of-range indices exist only when the index space exceeds the flag bank.
    generate
        if (N_FLAGS < (1 << IDX_W)) begin : g_oob
            localparam logic [IDX_W-1:0] IDX_LIM = IDX_W'(N_FLAGS);
            assign oob = (cmd_idx >= IDX_LIM);
        end else begin : g_no_oob
            assign oob = 1'b0;
        end
    endgenerate

    assign bad = (cmd_s & cmd_r) | oob;

    always_comb begin
        flags_nxt = flags;
        for (int f = 0; f < N_FLAGS; f++) begin
            if (!bad && (cmd_idx == IDX_W'(f))) begin
                if (cmd_s) begin
                    flags_nxt[f] = 1'b1;
                end else if (cmd_r) begin
                    flags_nxt[f] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            flags   <= '0;
            err     <= 1'b0;
            err_req <= '0;
            err_idx <= '0;
        end else if (gnt_any) begin
            rr_ptr <= 3'((int'(gnt_id) + 1) % N_REQ);
            flags  <= flags_nxt;
            // Only the first error is recorded; later ones leave the capture intact.
            if (bad && !err) begin
                err     <= 1'b1;
                err_req <= gnt_id;
                err_idx <= cmd_idx;
            end
        end
    end

`ifdef SR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_cnt <= '0;
        end else if (gnt_any) begin
            cmd_cnt <= cmd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed bench for sr_cmd_arbiter: default instance plus a 6-flag instance for range errors.
module tb_sr_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_s;
    logic [3:0]  req_r;
    logic [11:0] req_idx;

    logic [3:0]  req_ready;
    logic [7:0]  flags;
    logic        err;
    logic [2:0]  err_req;
    logic [2:0]  err_idx;

    logic [3:0]  req_ready6;
    logic [5:0]  flags6;
    logic        err6;
    logic [2:0]  err_req6;
    logic [2:0]  err_idx6;

`ifdef SR_ARB_STATS_EN
    logic [15:0] cmd_cnt;
    logic [15:0] cmd_cnt6;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sr_cmd_arbiter #(.N_REQ(4), .N_FLAGS(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_s(req_s), .req_r(req_r), .req_idx(req_idx),
        .req_ready(req_ready), .flags(flags),
        .err(err), .err_req(err_req), .err_idx(err_idx)
`ifdef SR_ARB_STATS_EN
        , .cmd_cnt(cmd_cnt)
`endif
    );

    sr_cmd_arbiter #(.N_REQ(4), .N_FLAGS(6), .IDX_W(3)) dut6 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_s(req_s), .req_r(req_r), .req_idx(req_idx),
        .req_ready(req_ready6), .flags(flags6),
        .err(err6), .err_req(err_req6), .err_idx(err_idx6)
`ifdef SR_ARB_STATS_EN
        , .cmd_cnt(cmd_cnt6)
`endif
    );

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_s     = '0;
        req_r     = '0;
        req_idx   = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drive(input int k, input logic s, input logic r, input logic [2:0] idx);
        req_valid[k]       = 1'b1;
        req_s[k]           = s;
        req_r[k]           = r;
        req_idx[k*3 +: 3]  = idx;
    endtask

    task automatic send(input int k, input logic s, input logic r, input logic [2:0] idx);
        drive(k, s, r, idx);
        cycle();
        clear_reqs();
    endtask

    task automatic test_reset();
        clear_reqs();
        req_valid = 4'hF;
        rst = 1'b1;
        cycle();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready1 got=%b exp=%b", req_ready, 4'b0000);
        end
        cycle();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready2 got=%b exp=%b", req_ready, 4'b0000);
        end
        checks++;
        if (flags !== 8'h00 || err !== 1'b0 || err_req !== 3'd0 || err_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got flags=%h err=%b req=%0d idx=%0d exp 00/0/0/0",
                     flags, err, err_req, err_idx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant got=%b exp=%b", req_ready, 4'b0001);
        end
        clear_reqs();
    endtask

    task automatic test_set_clear();
        drive(1, 1'b1, 1'b0, 3'd5);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL set_ready got=%b exp=%b", req_ready, 4'b0010);
        end
        cycle();
        checks++;
        if (flags !== 8'h20) begin
            failures++; $display("FAIL set_flags got=%h exp=%h", flags, 8'h20);
        end
        drive(1, 1'b0, 1'b1, 3'd5);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL clear_ready got=%b exp=%b", req_ready, 4'b0010);
        end
        cycle();
        checks++;
        if (flags !== 8'h00) begin
            failures++; $display("FAIL clear_flags got=%h exp=%h", flags, 8'h00);
        end
        clear_reqs();
    endtask

    task automatic test_round_robin();
        int cnt[4];
        logic [3:0] exp;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp = 4'b0001 << (c % 4);
            checks++;
            if (req_ready !== exp) begin
                failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, exp);
            end
            for (int k = 0; k < 4; k++) if (req_ready[k]) cnt[k]++;
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt[k] !== 2) begin
                failures++; $display("FAIL rr_count req=%0d got=%0d exp=2", k, cnt[k]);
            end
        end
        checks++;
        if (flags !== 8'h00 || err !== 1'b0) begin
            failures++; $display("FAIL rr_noop_state got flags=%h err=%b exp 00/0", flags, err);
        end
        clear_reqs();
    endtask

    task automatic test_illegal();
        do_reset();
        for (int i = 0; i < 4; i++) send(0, 1'b1, 1'b0, 3'(i));
        checks++;
        if (flags !== 8'h0F) begin
            failures++; $display("FAIL ill_setup got=%h exp=%h", flags, 8'h0F);
        end
        send(2, 1'b1, 1'b1, 3'd1);
        checks++;
        if (flags !== 8'h0F || err !== 1'b1 || err_req !== 3'd2 || err_idx !== 3'd1) begin
            failures++;
            $display("FAIL ill_first got flags=%h err=%b req=%0d idx=%0d exp 0f/1/2/1",
                     flags, err, err_req, err_idx);
        end
        send(3, 1'b1, 1'b1, 3'd6);
        checks++;
        if (flags !== 8'h0F || err !== 1'b1 || err_req !== 3'd2 || err_idx !== 3'd1) begin
            failures++;
            $display("FAIL ill_sticky got flags=%h err=%b req=%0d idx=%0d exp 0f/1/2/1",
                     flags, err, err_req, err_idx);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        send(0, 1'b1, 1'b0, 3'd2);
        send(0, 1'b1, 1'b0, 3'd7);
        checks++;
        if (flags6 !== 6'h04 || err6 !== 1'b1 || err_req6 !== 3'd0 || err_idx6 !== 3'd7) begin
            failures++;
            $display("FAIL oob_small got flags=%h err=%b req=%0d idx=%0d exp 04/1/0/7",
                     flags6, err6, err_req6, err_idx6);
        end
        checks++;
        if (flags !== 8'h84 || err !== 1'b0) begin
            failures++; $display("FAIL oob_full got flags=%h err=%b exp 84/0", flags, err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(0, 1'b1, 1'b0, 3'd4);
        drive(3, 1'b1, 1'b0, 3'd6);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL mid_first got=%b exp=%b", req_ready, 4'b0001);
        end
        cycle();
        checks++;
        if (flags !== 8'h10 || req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL mid_pending got flags=%h ready=%b exp 10/1000", flags, req_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL mid_rst_ready got=%b exp=%b", req_ready, 4'b0000);
        end
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (flags !== 8'h00 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_after got flags=%h ready=%b exp 00/0001", flags, req_ready);
        end
`ifdef SR_ARB_STATS_EN
        checks++;
        if (cmd_cnt !== 16'd0) begin
            failures++; $display("FAIL cnt_reset got=%0d exp=0", cmd_cnt);
        end
        cycle();
        checks++;
        if (cmd_cnt !== 16'd1) begin
            failures++; $display("FAIL cnt_one got=%0d exp=1", cmd_cnt);
        end
        cycle();
        checks++;
        if (cmd_cnt !== 16'd2) begin
            failures++; $display("FAIL cnt_two got=%0d exp=2", cmd_cnt);
        end
`else
        cycle();
        cycle();
`endif
        checks++;
        if (flags !== 8'h50) begin
            failures++; $display("FAIL mid_resume got=%h exp=%h", flags, 8'h50);
        end
        clear_reqs();
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        test_reset();
        test_set_clear();
        test_round_robin();
        test_illegal();
        test_out_of_range();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
